// File: rtl/eros_addr_map_unit.sv
// Runtime-programmable address decoder with shadow/active rule tables, sticky lock and a
// one-stage valid/ready lookup pipeline. Optional miss logging under EROS_AMU_MISS_LOG_EN.
module eros_addr_map_unit #(
  parameter int unsigned NUM_RULES   = 5,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned IDX_WIDTH   = 3,
  parameter int unsigned DEFAULT_IDX = 0,
  localparam int unsigned RULE_W     = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cfg_we_i,
  input  logic [RULE_W-1:0]     cfg_rule_i,
  input  logic [1:0]            cfg_field_i,
  input  logic [ADDR_WIDTH-1:0] cfg_wdata_i,
  input  logic                  cfg_commit_i,
  input  logic                  cfg_lock_i,
  output logic                  cfg_locked_o,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [IDX_WIDTH-1:0]  resp_idx_o,
  output logic                  resp_hit_o,
  output logic                  resp_multi_o
`ifdef EROS_AMU_MISS_LOG_EN
  ,
  input  logic                  miss_clr_i,
  output logic [15:0]           miss_cnt_o,
  output logic [ADDR_WIDTH-1:0] miss_addr_o,
  output logic                  miss_valid_o
`endif
);

  localparam logic [IDX_WIDTH-1:0] DefIdx = IDX_WIDTH'(DEFAULT_IDX);

  logic [ADDR_WIDTH-1:0] sh_start_q  [NUM_RULES];
  logic [ADDR_WIDTH-1:0] sh_end_q    [NUM_RULES];
  logic [IDX_WIDTH-1:0]  sh_idx_q    [NUM_RULES];
  logic                  sh_en_q     [NUM_RULES];
  logic [ADDR_WIDTH-1:0] sh_start_d  [NUM_RULES];
  logic [ADDR_WIDTH-1:0] sh_end_d    [NUM_RULES];
  logic [IDX_WIDTH-1:0]  sh_idx_d    [NUM_RULES];
  logic                  sh_en_d     [NUM_RULES];
  logic [ADDR_WIDTH-1:0] act_start_q [NUM_RULES];
  logic [ADDR_WIDTH-1:0] act_end_q   [NUM_RULES];
  logic [IDX_WIDTH-1:0]  act_idx_q   [NUM_RULES];
  logic                  act_en_q    [NUM_RULES];

  logic                  locked_q;
  logic                  we_en;
  logic                  commit_en;
  logic                  accept;
  logic                  lk_hit;
  logic                  lk_multi;
  logic [IDX_WIDTH-1:0]  lk_idx;
  logic                  resp_valid_q;
  logic [IDX_WIDTH-1:0]  resp_idx_q;
  logic                  resp_hit_q;
  logic                  resp_multi_q;

  assign we_en     = cfg_we_i && !locked_q && (32'(cfg_rule_i) < NUM_RULES);
  assign commit_en = cfg_commit_i && !locked_q;

  // Next shadow state; commit copies this so a same-cycle write is included.
  always_comb begin
    sh_start_d = sh_start_q;
    sh_end_d   = sh_end_q;
    sh_idx_d   = sh_idx_q;
    sh_en_d    = sh_en_q;
    for (int i = 0; i < NUM_RULES; i++) begin
      if (we_en && (32'(cfg_rule_i) == i)) begin
        unique case (cfg_field_i)
          2'd0:    sh_start_d[i] = cfg_wdata_i;
          2'd1:    sh_end_d[i]   = cfg_wdata_i;
          2'd2:    sh_idx_d[i]   = cfg_wdata_i[IDX_WIDTH-1:0];
          default: sh_en_d[i]    = cfg_wdata_i[0];
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_RULES; i++) begin
        sh_start_q[i]  <= '0;
        sh_end_q[i]    <= '0;
        sh_idx_q[i]    <= '0;
        sh_en_q[i]     <= 1'b0;
        act_start_q[i] <= '0;
        act_end_q[i]   <= '0;
        act_idx_q[i]   <= '0;
        act_en_q[i]    <= 1'b0;
      end
      locked_q <= 1'b0;
    end else begin
      sh_start_q <= sh_start_d;
      sh_end_q   <= sh_end_d;
      sh_idx_q   <= sh_idx_d;
      sh_en_q    <= sh_en_d;
      if (commit_en) begin
        act_start_q <= sh_start_d;
        act_end_q   <= sh_end_d;
        act_idx_q   <= sh_idx_d;
        act_en_q    <= sh_en_d;
      end
      if (cfg_lock_i) begin
        locked_q <= 1'b1;
      end
    end
  end

  // Lowest-numbered match wins; any later match flags an overlap.
  always_comb begin
    lk_hit   = 1'b0;
    lk_multi = 1'b0;
    lk_idx   = DefIdx;
    for (int i = 0; i < NUM_RULES; i++) begin
      if (act_en_q[i] && (req_addr_i >= act_start_q[i]) && (req_addr_i < act_end_q[i])) begin
        if (lk_hit) begin
          lk_multi = 1'b1;
        end else begin
          lk_hit = 1'b1;
          lk_idx = act_idx_q[i];
        end
      end
    end
  end

  assign req_ready_o = !resp_valid_q || resp_ready_i;
  assign accept      = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid_q <= 1'b0;
      resp_idx_q   <= DefIdx;
      resp_hit_q   <= 1'b0;
      resp_multi_q <= 1'b0;
    end else if (accept) begin
      resp_valid_q <= 1'b1;
      resp_idx_q   <= lk_idx;
      resp_hit_q   <= lk_hit;
      resp_multi_q <= lk_multi;
    end else if (resp_ready_i) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign cfg_locked_o = locked_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_idx_o   = resp_idx_q;
  assign resp_hit_o   = resp_hit_q;
  assign resp_multi_o = resp_multi_q;

`ifdef EROS_AMU_MISS_LOG_EN
  logic [15:0]           miss_cnt_q;
  logic [ADDR_WIDTH-1:0] miss_addr_q;
  logic                  miss_valid_q;

  // Clear wins over a same-cycle miss, which is then neither counted nor captured.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      miss_cnt_q   <= '0;
      miss_addr_q  <= '0;
      miss_valid_q <= 1'b0;
    end else if (miss_clr_i) begin
      miss_cnt_q   <= '0;
      miss_addr_q  <= '0;
      miss_valid_q <= 1'b0;
    end else if (accept && !lk_hit) begin
      if (miss_cnt_q != 16'hFFFF) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
      if (!miss_valid_q) begin
        miss_addr_q  <= req_addr_i;
        miss_valid_q <= 1'b1;
      end
    end
  end

  assign miss_cnt_o   = miss_cnt_q;
  assign miss_addr_o  = miss_addr_q;
  assign miss_valid_o = miss_valid_q;
`endif

endmodule
